// File: rtl/regfile_op_sequencer.sv
// ---------------------------------------------------------------------------
// regfile_op_sequencer
//
// Multi-cycle controller that sits in front of an 8x32 register file and owns
// its single write path (Addr/regWE/DataIn). It also uses the file's
// combinational read port (DataOut, which follows Addr). For each request it:
//   1. reads source A,
//   2. reads source B on the next cycle,
//   3. computes a WIDTH-bit ALU result,
//   4. writes the result to the destination register,
//   5. pulses done for one cycle, then returns to IDLE.
// Sequence: IDLE -> READ_A -> READ_B -> EXEC -> WRITE -> DONE -> IDLE.
// A new request can be accepted at most once every 6 cycles.
//
// Ports
//   clk      in   rising-edge clock
//   CLR      in   synchronous active-high reset (shared with register file)
//   start    in   request, sampled only in IDLE
//   op       in   operation code, captured with start
//   srcA     in   first source register, captured with start
//   srcB     in   second source register, captured with start
//   dst      in   destination register, captured with start
//   imm      in   immediate used by LDI, captured with start
//   busy     out  high in every state except IDLE
//   done     out  one-cycle pulse in DONE
//   zero     out  last result == 0
//   carry    out  ADD carry-out / SUB borrow, otherwise 0
//   Addr     out  register file address
//   regWE    out  register file write enable
//   DataIn   out  register file write data (always the result register)
//   DataOut  in   register file read data for the current Addr
// ---------------------------------------------------------------------------
module regfile_op_sequencer #(
  parameter int WIDTH = 32,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             CLR,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [AW-1:0]    srcA,
  input  logic [AW-1:0]    srcB,
  input  logic [AW-1:0]    dst,
  input  logic [WIDTH-1:0] imm,
  output logic             busy,
  output logic             done,
  output logic             zero,
  output logic             carry,
  output logic [AW-1:0]    Addr,
  output logic             regWE,
  output logic [WIDTH-1:0] DataIn,
  input  logic [WIDTH-1:0] DataOut
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ_A = 3'd1,
    S_READ_B = 3'd2,
    S_EXEC   = 3'd3,
    S_WRITE  = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SLL = 3'b101,
    OP_SRL = 3'b110,
    OP_LDI = 3'b111
  } op_e;

  state_e           state_q;
  op_e              op_q;
  logic [AW-1:0]    src_a_q, src_b_q, dst_q;
  logic [WIDTH-1:0] imm_q;
  logic [WIDTH-1:0] op_a_q, op_b_q, result_q;
  logic             zero_q, carry_q;
  logic [AW-1:0]    addr_q;
  logic             reg_we_q, busy_q, done_q;

  logic [WIDTH-1:0] result_d;
  logic             carry_d;
  logic [WIDTH:0]   wide_sum;
  logic [WIDTH:0]   wide_diff;

  // ALU on the captured operands. The extra top bit of the widened add and
  // subtract holds the carry-out and the borrow, respectively.
  // NOTE: every always_comb output gets a default first so that no path
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    result_d  = '0;
    carry_d   = 1'b0;
    wide_sum  = {1'b0, op_a_q} + {1'b0, op_b_q};
    wide_diff = {1'b0, op_a_q} - {1'b0, op_b_q};
    unique case (op_q)
      OP_ADD: begin
        result_d = wide_sum[WIDTH-1:0];
        carry_d  = wide_sum[WIDTH];
      end
      OP_SUB: begin
        result_d = wide_diff[WIDTH-1:0];
        carry_d  = wide_diff[WIDTH];
      end
      OP_AND:  result_d = op_a_q & op_b_q;
      OP_OR:   result_d = op_a_q | op_b_q;
      OP_XOR:  result_d = op_a_q ^ op_b_q;
      // Only B[4:0] sets the shift amount; the upper bits of B are ignored.
      OP_SLL:  result_d = op_a_q << op_b_q[4:0];
      OP_SRL:  result_d = op_a_q >> op_b_q[4:0];
      OP_LDI:  result_d = imm_q;
      default: result_d = '0;
    endcase
  end

  // Single-process FSM. The outputs are registered: each transition loads the
  // output values of the state being entered, so Addr/regWE/busy/done depend
  // on the current state only.
  // NOTE: state is updated with non-blocking assignments only, so every
  // register samples values from before the clock edge.
  always_ff @(posedge clk) begin
    if (CLR) begin
      state_q  <= S_IDLE;
      op_q     <= OP_ADD;
      src_a_q  <= '0;
      src_b_q  <= '0;
      dst_q    <= '0;
      imm_q    <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      addr_q   <= '0;
      reg_we_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            op_q    <= op_e'(op);
            src_a_q <= srcA;
            src_b_q <= srcB;
            dst_q   <= dst;
            imm_q   <= imm;
            state_q <= S_READ_A;
            addr_q  <= srcA;
            busy_q  <= 1'b1;
          end
        end
        S_READ_A: begin
          op_a_q  <= DataOut;
          state_q <= S_READ_B;
          addr_q  <= src_b_q;
        end
        S_READ_B: begin
          op_b_q  <= DataOut;
          state_q <= S_EXEC;
          addr_q  <= '0;
        end
        S_EXEC: begin
          result_q <= result_d;
          zero_q   <= (result_d == '0);
          carry_q  <= carry_d;
          state_q  <= S_WRITE;
          addr_q   <= dst_q;
          reg_we_q <= 1'b1;
        end
        S_WRITE: begin
          state_q  <= S_DONE;
          addr_q   <= '0;
          reg_we_q <= 1'b0;
          done_q   <= 1'b1;
        end
        S_DONE: begin
          // A start seen here is dropped, not queued.
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q  <= S_IDLE;
          addr_q   <= '0;
          reg_we_q <= 1'b0;
          busy_q   <= 1'b0;
          done_q   <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign zero   = zero_q;
  assign carry  = carry_q;
  assign Addr   = addr_q;
  assign regWE  = reg_we_q;
  assign DataIn = result_q;

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// ---------------------------------------------------------------------------
// tb_regfile_op_sequencer
//
// Drives regfile_op_sequencer against a behavioural 8x32 register file.
// Expected register contents and flags come from an operation-level model:
// each request is applied to a plain array in a single step.
// ---------------------------------------------------------------------------
module tb_regfile_op_sequencer;

  localparam int WIDTH = 32;
  localparam int AW    = 3;

  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011,
                         XOR_ = 3'b100, SLL = 3'b101, SRL = 3'b110, LDI = 3'b111;

  logic             clk = 1'b0;
  logic             CLR = 1'b1;
  logic             start = 1'b0;
  logic [2:0]       op = '0;
  logic [AW-1:0]    srcA = '0, srcB = '0, dst = '0;
  logic [WIDTH-1:0] imm = '0;
  logic             busy, done, zero, carry, regWE;
  logic [AW-1:0]    Addr;
  logic [WIDTH-1:0] DataIn, DataOut;

  int tests_run = 0;
  int tests_failed = 0;

  regfile_op_sequencer #(.WIDTH(WIDTH), .AW(AW)) dut (
    .clk(clk), .CLR(CLR), .start(start), .op(op), .srcA(srcA), .srcB(srcB),
    .dst(dst), .imm(imm), .busy(busy), .done(done), .zero(zero), .carry(carry),
    .Addr(Addr), .regWE(regWE), .DataIn(DataIn), .DataOut(DataOut)
  );

  always #5 clk = ~clk;

  // Behavioural register file: clears on CLR, writes at the edge, reads combinationally.
  logic [WIDTH-1:0] rf [8];
  always @(posedge clk) begin
    if (CLR) begin
      for (int i = 0; i < 8; i++) rf[i] <= '0;
    end else if (regWE) begin
      rf[Addr] <= DataIn;
    end
  end
  assign DataOut = rf[Addr];

  // Count of write strobes and done pulses seen at clock edges.
  int we_cnt = 0;
  int done_cnt = 0;
  always @(posedge clk) begin
    if (!CLR && regWE) we_cnt <= we_cnt + 1;
    if (!CLR && done)  done_cnt <= done_cnt + 1;
  end

  // Reference model state.
  logic [WIDTH-1:0] exp_rf [8];
  logic             exp_zero, exp_carry;

  function automatic void model_clear();
    for (int i = 0; i < 8; i++) exp_rf[i] = '0;
    exp_zero  = 1'b0;
    exp_carry = 1'b0;
  endfunction

  function automatic void model_apply(input logic [2:0] o, input logic [AW-1:0] a, b, d,
                                      input logic [WIDTH-1:0] im);
    logic [WIDTH-1:0] va, vb, res;
    logic [WIDTH:0]   wide;
    logic             cy;
    va = exp_rf[a];
    vb = exp_rf[b];
    cy = 1'b0;
    case (o)
      ADD:     begin wide = {1'b0, va} + {1'b0, vb}; res = wide[WIDTH-1:0]; cy = wide[WIDTH]; end
      SUB:     begin res = va - vb; cy = (va < vb); end
      AND_:    res = va & vb;
      OR_:     res = va | vb;
      XOR_:    res = va ^ vb;
      SLL:     res = va << vb[4:0];
      SRL:     res = va >> vb[4:0];
      default: res = im;
    endcase
    exp_rf[d] = res;
    exp_zero  = (res == '0);
    exp_carry = cy;
  endfunction

  // Issues one request starting at a negedge and returns at the negedge after
  // done has dropped. lat counts the edges from the accepting edge through the
  // edge that raises done. If poke is set, start is raised again while done is
  // high; that second request must be ignored.
  task automatic issue(input logic [2:0] o, input logic [AW-1:0] a, b, d,
                       input logic [WIDTH-1:0] im, input bit poke, output int lat);
    model_apply(o, a, b, d, im);
    op = o; srcA = a; srcB = b; dst = d; imm = im; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Scramble the request fields after capture; the operation must not see them.
    op = 3'($urandom); srcA = AW'($urandom); srcB = AW'($urandom);
    dst = AW'($urandom); imm = $urandom;
    lat = 1;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (poke) begin
      op = LDI; dst = 3'd0; imm = 32'hDEAD_BEEF; start = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    int lat, we0;
    CLR = 1'b1;
    model_clear();
    repeat (2) @(negedge clk);
    tests_run++;
    if ({busy, done, regWE, zero, carry} !== 5'b0 || Addr !== '0 || DataIn !== '0) begin
      tests_failed++;
      $display("FAIL reset_state: busy=%b done=%b regWE=%b zero=%b carry=%b Addr=%0d DataIn=%h, want all 0",
               busy, done, regWE, zero, carry, Addr, DataIn);
    end
    CLR = 1'b0;
    @(negedge clk);
    issue(LDI, 3'd0, 3'd0, 3'd1, 32'd5, 1'b0, lat);
    // Start ADD R1,R1->R2, then clear while the FSM is in READ_B.
    op = ADD; srcA = 3'd1; srcB = 3'd1; dst = 3'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    CLR = 1'b1;
    model_clear();
    we0 = we_cnt;
    @(negedge clk);
    CLR = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || regWE !== 1'b0 || Addr !== '0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL clr_mid_op: busy=%b regWE=%b Addr=%0d done=%b, want 0 0 0 0", busy, regWE, Addr, done);
    end
    repeat (8) @(negedge clk);
    tests_run++;
    if (we_cnt !== we0) begin
      tests_failed++;
      $display("FAIL clr_no_write: %0d writes after abort, want 0", we_cnt - we0);
    end
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (rf[i] !== exp_rf[i]) begin
        tests_failed++;
        $display("FAIL clr_rf[%0d]: got %h want %h", i, rf[i], exp_rf[i]);
      end
    end
  endtask

  task automatic test_ldi_add();
    int lat;
    logic [2:0]  ops [3] = '{LDI, LDI, ADD};
    logic [31:0] ims [3] = '{32'd5, 32'd3, 32'd0};
    logic [2:0]  dsts [3] = '{3'd1, 3'd2, 3'd3};
    for (int k = 0; k < 3; k++) begin
      issue(ops[k], 3'd1, 3'd2, dsts[k], ims[k], 1'b0, lat);
      tests_run++;
      if (lat !== 5) begin
        tests_failed++;
        $display("FAIL ldi_add_latency[%0d]: done after %0d cycles, want 5", k, lat);
      end
    end
    tests_run++;
    if (rf[3] !== 32'd8 || zero !== 1'b0 || carry !== 1'b0) begin
      tests_failed++;
      $display("FAIL ldi_add_result: R3=%h zero=%b carry=%b, want 00000008 0 0", rf[3], zero, carry);
    end
  endtask

  task automatic test_add_carry_sub();
    int lat;
    issue(LDI, 3'd0, 3'd0, 3'd1, 32'hFFFF_FFFF, 1'b0, lat);
    issue(LDI, 3'd0, 3'd0, 3'd2, 32'h1, 1'b0, lat);
    issue(ADD, 3'd1, 3'd2, 3'd4, 32'h0, 1'b0, lat);
    tests_run++;
    if (rf[4] !== 32'h0 || zero !== 1'b1 || carry !== 1'b1) begin
      tests_failed++;
      $display("FAIL add_carry: R4=%h zero=%b carry=%b, want 00000000 1 1", rf[4], zero, carry);
    end
    issue(SUB, 3'd2, 3'd1, 3'd5, 32'h0, 1'b0, lat);
    tests_run++;
    if (rf[5] !== 32'h2 || zero !== 1'b0 || carry !== 1'b1) begin
      tests_failed++;
      $display("FAIL sub_borrow: R5=%h zero=%b carry=%b, want 00000002 0 1", rf[5], zero, carry);
    end
  endtask

  task automatic test_shifts();
    int lat;
    issue(LDI, 3'd0, 3'd0, 3'd1, 32'h8000_0001, 1'b0, lat);
    issue(LDI, 3'd0, 3'd0, 3'd2, 32'h21, 1'b0, lat);
    issue(SLL, 3'd1, 3'd2, 3'd6, 32'h0, 1'b0, lat);
    tests_run++;
    if (rf[6] !== 32'h2 || carry !== 1'b0) begin
      tests_failed++;
      $display("FAIL sll: R6=%h carry=%b, want 00000002 0", rf[6], carry);
    end
    issue(SRL, 3'd1, 3'd2, 3'd7, 32'h0, 1'b0, lat);
    tests_run++;
    if (rf[7] !== 32'h4000_0000) begin
      tests_failed++;
      $display("FAIL srl: R7=%h, want 40000000", rf[7]);
    end
  endtask

  task automatic test_xor_done_start();
    int lat, we0;
    logic [31:0] r0_before;
    issue(LDI, 3'd0, 3'd0, 3'd3, 32'd8, 1'b0, lat);
    r0_before = exp_rf[0];
    issue(XOR_, 3'd3, 3'd3, 3'd3, 32'h0, 1'b1, lat);
    we0 = we_cnt;
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL done_start_busy: busy=%b after DONE, want 0", busy);
    end
    tests_run++;
    if (rf[3] !== 32'h0 || zero !== 1'b1) begin
      tests_failed++;
      $display("FAIL xor_self: R3=%h zero=%b, want 00000000 1", rf[3], zero);
    end
    repeat (8) @(negedge clk);
    tests_run++;
    if (we_cnt !== we0 || rf[0] !== r0_before || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL done_start_ignored: writes=%0d R0=%h busy=%b, want 0 %h 0",
               we_cnt - we0, rf[0], busy, r0_before);
    end
  endtask

  task automatic test_start_held();
    int we0, dn0;
    we0 = we_cnt;
    dn0 = done_cnt;
    op = ADD; srcA = 3'd6; srcB = 3'd1; dst = 3'd6; imm = '0;
    start = 1'b1;
    repeat (12) @(negedge clk);
    start = 1'b0;
    model_apply(ADD, 3'd6, 3'd1, 3'd6, '0);
    model_apply(ADD, 3'd6, 3'd1, 3'd6, '0);
    repeat (10) @(negedge clk);
    tests_run++;
    if (we_cnt - we0 !== 2 || done_cnt - dn0 !== 2) begin
      tests_failed++;
      $display("FAIL start_held: writes=%0d dones=%0d, want 2 2", we_cnt - we0, done_cnt - dn0);
    end
    tests_run++;
    if (rf[6] !== exp_rf[6]) begin
      tests_failed++;
      $display("FAIL start_held_result: R6=%h want %h", rf[6], exp_rf[6]);
    end
  endtask

  task automatic test_random();
    int lat;
    logic [2:0]    o;
    logic [AW-1:0] a, b, d;
    for (int k = 0; k < 40; k++) begin
      o = 3'($urandom);
      a = AW'($urandom); b = AW'($urandom); d = AW'($urandom);
      issue(o, a, b, d, $urandom, 1'b0, lat);
      tests_run++;
      if (lat !== 5 || rf[d] !== exp_rf[d] || zero !== exp_zero || carry !== exp_carry) begin
        tests_failed++;
        $display("FAIL random[%0d] op=%0d a=%0d b=%0d d=%0d: lat=%0d R=%h z=%b c=%b, want 5 %h %b %b",
                 k, o, a, b, d, lat, rf[d], zero, carry, exp_rf[d], exp_zero, exp_carry);
      end
    end
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (rf[i] !== exp_rf[i]) begin
        tests_failed++;
        $display("FAIL random_rf[%0d]: got %h want %h", i, rf[i], exp_rf[i]);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_ldi_add();
    test_add_carry_sub();
    test_shifts();
    test_xor_done_start();
    test_start_held();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
